// File: rtl/pcie_wr_source.sv
// Streams 64-bit words through a 64-deep FIFO and issues 16-word write bursts
// into a host ring buffer, honouring the host read pointer for flow control.
module pcie_wr_source (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] buffer_base,
    input  logic [15:0] buffer_bursts,
    input  logic [15:0] host_ptr,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] write_ptr,
    output logic        write_request_valid,
    output logic [63:0] write_request_address,
    output logic [63:0] write_request_data,
    input  logic        write_request_ready,
    input  logic        write_request_ack
);

    typedef enum logic [1:0] {StIdle, StReq, StBurst} state_e;

    localparam logic [6:0] FifoDepth   = 7'd64;
    localparam logic [4:0] BurstBeats  = 5'd16;

    state_e      state_q, state_d;
    logic [4:0]  beat_q, beat_d;
    logic [63:0] mem [64];
    logic [5:0]  wr_ptr_q, rd_ptr_q;
    logic [6:0]  count_q, count_d;
    logic        push, pop, active, ring_full;
    logic [15:0] wp_inc, wp_next, wp_d;
    logic        valid_d;
    logic [63:0] addr_d;
    logic        err_extra_pop;

    assign active = (state_q != StIdle);
    assign push   = din_valid && din_ready;
    // Pops arriving in REQ ahead of the ack still count toward the burst.
    assign pop    = write_request_ready && active && (beat_q < BurstBeats) &&
                    (count_q != 7'd0);

    assign wp_inc    = write_ptr + 16'd1;
    assign wp_next   = (wp_inc == buffer_bursts) ? 16'd0 : wp_inc;
    assign ring_full = (wp_next == host_ptr);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 7'd1;
        end else if (pop && !push) begin
            count_d = count_q - 7'd1;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            beat_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        beat_d  = pop ? beat_q + 5'd1 : beat_q;
        unique case (state_q)
            StIdle: begin
                if (enable && (count_q >= 7'd16) && !ring_full) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (write_request_ack) begin
                    if (beat_d == BurstBeats) begin
                        state_d = StIdle;
                        beat_d  = 5'd0;
                    end else begin
                        state_d = StBurst;
                    end
                end
            end
            StBurst: begin
                if (beat_d == BurstBeats) begin
                    state_d = StIdle;
                    beat_d  = 5'd0;
                end
            end
            default: begin
                state_d = StIdle;
                beat_d  = 5'd0;
            end
        endcase
    end

    // Output logic: request fields are loaded on entry to REQ, write_ptr on ack.
    always_comb begin
        valid_d = write_request_valid;
        addr_d  = write_request_address;
        wp_d    = write_ptr;
        if (state_q == StIdle && state_d == StReq) begin
            valid_d = 1'b1;
            addr_d  = (buffer_base & ~64'h7f) + {41'd0, write_ptr, 7'd0};
        end
        if (state_q == StReq && write_request_ack) begin
            valid_d = 1'b0;
            wp_d    = wp_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q              <= 6'd0;
            rd_ptr_q              <= 6'd0;
            count_q               <= 7'd0;
            din_ready             <= 1'b0;
            write_ptr             <= 16'd0;
            write_request_valid   <= 1'b0;
            write_request_address <= 64'd0;
            write_request_data    <= 64'd0;
            err_extra_pop         <= 1'b0;
        end else begin
            count_q               <= count_d;
            din_ready             <= (count_d != FifoDepth);
            write_ptr             <= wp_d;
            write_request_valid   <= valid_d;
            write_request_address <= addr_d;
            err_extra_pop         <= err_extra_pop || (write_request_ready && !pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 6'd1;
            end
            if (pop) begin
                rd_ptr_q           <= rd_ptr_q + 6'd1;
                write_request_data <= mem[rd_ptr_q];
            end
        end
    end

endmodule
